// File: rtl/counter_range_sched.sv
// Shared up-counter scheduler: a two-way arbiter grants one [start, end] window at a time.
// Optional feature: define RR_ARB_EN for round-robin arbitration; otherwise req0 has fixed priority.
module counter_range_sched #(
    parameter int WIDTH = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] start0,
    input  logic [WIDTH-1:0] end0,
    input  logic             req1,
    input  logic [WIDTH-1:0] start1,
    input  logic [WIDTH-1:0] end1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             done,
    output logic             done_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;

    logic [1:0]       req_vec;
    logic [WIDTH-1:0] start_sel;
    logic [WIDTH-1:0] end_sel;
    logic             any_req;
    logic             winner;
    logic             at_end;
    logic [1:0]       gnt_vec;

    assign req_vec = {req1, req0};
    assign any_req = |req_vec;
    assign at_end  = (count_q == end_q);

    // Arbitration: only meaningful when any_req is high.
    always_comb begin
        winner = 1'b0;
`ifdef RR_ARB_EN
        if (req0 && req1)
            winner = ptr_q;
        else
            winner = req1;
`else
        winner = !req0;
`endif
    end

    always_comb begin
        start_sel = winner ? start1 : start0;
        end_sel   = winner ? end1   : end0;
    end

    // State register and job registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            end_q   <= '0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            end_q   <= end_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_COUNT;
            ST_COUNT: if (at_end)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job datapath: window endpoints are captured only on the grant edge.
    always_comb begin
        count_d = count_q;
        end_d   = end_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    count_d = start_sel;
                    end_d   = end_sel;
                    owner_d = winner;
`ifdef RR_ARB_EN
                    ptr_d   = !winner;
`endif
                end
            end
            ST_COUNT: begin
                // Natural modulo-2^WIDTH wrap handles end < start.
                if (!at_end)
                    count_d = count_q + WIDTH'(1);
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_vec[gi] = (state_q == ST_COUNT) && (owner_q == 1'(gi));
        end
    endgenerate

    // Output logic.
    always_comb begin
        gnt0        = gnt_vec[0];
        gnt1        = gnt_vec[1];
        busy        = (state_q != ST_IDLE);
        count       = count_q;
        count_valid = (state_q == ST_COUNT);
        done        = (state_q == ST_DONE);
        done_id     = (state_q == ST_DONE) && owner_q;
    end

endmodule

// File: tb/tb_counter_range_sched.sv
// Directed bench for counter_range_sched: single windows, wrap, arbitration order, reset abort.
module tb_counter_range_sched;

    localparam int WIDTH = 7;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0] start0 = '0, end0 = '0, start1 = '0, end1 = '0;
    logic             gnt0, gnt1, busy, count_valid, done, done_id;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int failures = 0;

    counter_range_sched #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .start0(start0), .end0(end0),
        .req1(req1), .start1(start1), .end1(end1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .count(count),
        .count_valid(count_valid), .done(done), .done_id(done_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else
            $display("ok   %s: %0d", tag, obs);
    endtask

    function automatic int outs();
        return {gnt0, gnt1, busy, count, count_valid, done, done_id};
    endfunction

    // Runs one job from IDLE; n is the hand-computed window length.
    task automatic run_window(input int id, input int s, input int e, input int n);
        if (id == 0) begin req0 = 1'b1; start0 = s[WIDTH-1:0]; end0 = e[WIDTH-1:0]; end
        else         begin req1 = 1'b1; start1 = s[WIDTH-1:0]; end1 = e[WIDTH-1:0]; end
        @(negedge clock);
        check("grant_gnt0", int'(gnt0), (id == 0) ? 1 : 0);
        check("grant_gnt1", int'(gnt1), (id == 1) ? 1 : 0);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("step_count", int'(count), (s + i) % 128);
            check("step_valid", int'(count_valid), 1);
            @(negedge clock);
        end
        check("done_pulse", int'(done), 1);
        check("done_id", int'(done_id), id);
        check("done_valid", int'(count_valid), 0);
        check("done_gnt", int'(gnt0 | gnt1), 0);
        check("done_count_hold", int'(count), e);
        @(negedge clock);
        check("after_busy", int'(busy), 0);
        check("after_done", int'(done), 0);
    endtask

    initial begin
        int got[4];
        int njobs;
        int gnt1_seen;
        logic prev_valid;

        // 1: reset, then idle with no requests
        repeat (3) @(negedge clock);
        check("reset_outs", outs(), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_outs", outs(), 0);
        end

        // 2: 7..77 on requester 0, 71 valid cycles
        run_window(0, 7, 77, 71);

        // 3: wrap 125..2 on requester 1, 6 valid cycles
        run_window(1, 125, 2, 6);

        // 4: both requesters held high, 3-step windows
        start0 = 7'd10; end0 = 7'd12;
        start1 = 7'd20; end1 = 7'd22;
        req0 = 1'b1; req1 = 1'b1;
        njobs = 0; gnt1_seen = 0; prev_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && njobs < 4; cyc++) begin
            @(negedge clock);
            if (count_valid && !prev_valid) begin
                got[njobs] = int'(gnt1);
                njobs++;
            end
            if (gnt1) gnt1_seen++;
            prev_valid = count_valid;
        end
        check("arb_jobs_seen", njobs, 4);
`ifdef RR_ARB_EN
        check("arb_order0", got[0], 0);
        check("arb_order1", got[1], 1);
        check("arb_order2", got[2], 0);
        check("arb_order3", got[3], 1);
`else
        check("arb_order0", got[0], 0);
        check("arb_order1", got[1], 0);
        check("arb_order2", got[2], 0);
        check("arb_order3", got[3], 0);
        check("arb_gnt1_never", gnt1_seen, 0);
`endif
        req0 = 1'b0; req1 = 1'b0;
        for (int cyc = 0; cyc < 10 && busy; cyc++) @(negedge clock);
        check("arb_drain_idle", int'(busy), 0);

        // 5: reset mid-COUNT abandons the job
        req0 = 1'b1; start0 = 7'd50; end0 = 7'd60;
        @(negedge clock);
        req0 = 1'b0;
        repeat (3) @(negedge clock);
        check("midjob_count", int'(count), 53);
        reset = 1'b0;
        #1;
        check("abort_outs", outs(), 0);
        @(negedge clock);
        reset = 1'b1;
        gnt1_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done || busy) gnt1_seen++;
        end
        check("abort_no_done", gnt1_seen, 0);
        run_window(0, 50, 60, 11);

        // 6: single-step window
        run_window(0, 40, 40, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
